vga_sync: RTL and testbench



---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_sync_wrap_counter.sv | 48 ++++
 rtl/vga_sync.sv | 138 +++++++++++++
 tb/tb_vga_sync.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared raster timing constants for the 640x480@60 Hz display pipeline.
// Renderers import this package for screen bounds and coordinate widths.
// Pure constants and helpers: no logic, no latency, no backpressure.
package vga_pkg;

    // Coordinate and frame counter widths
    localparam int COORD_W     = 10;
    localparam int FRAME_CNT_W = 16;

    // Horizontal timing, in pixel clocks
    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    // Vertical timing, in lines
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Level driven on hsync/vsync while the pulse is asserted
    localparam logic VGA_SYNC_ACTIVE = 1'b0;

    // Half-open window test [lo, hi) on unsigned coordinates
    function automatic logic in_window(
        input logic [COORD_W-1:0] c,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_sync_wrap_counter.sv
// Modulo-N up counter with enable and a wrap indication, exposes next state.
// Latency: count_o is registered; next_o and wrap_o are combinational.
// No backpressure; out-of-range values fall back to 0 on the next edge.
module wrap_counter #(
    parameter int W = 10,
    parameter int N = 800
) (
    input  logic         clk25M,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] next_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next value: illegal states recover unconditionally, otherwise count when enabled
    always_comb begin
        count_d = count_q;
        if (count_q > LAST) begin
            count_d = '0;
        end else if (en_i) begin
            if (count_q == LAST) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Counter register, cleared immediately by reset
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign next_o  = count_d;
    assign wrap_o  = en_i && (count_q >= LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA raster generator: x/y, hsync/vsync, video_on, frame_tick, frame_count.
// Latency: flags are registered from next-state x/y, so they align with x/y.
// Free running, no backpressure. VGA_SYNC_FRAME_CNT_EN enables frame_count.
module vga_sync
    import vga_pkg::*;
#(
    parameter int   H_DISPLAY   = VGA_H_DISPLAY,
    parameter int   H_FRONT     = VGA_H_FRONT,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BACK      = VGA_H_BACK,
    parameter int   V_DISPLAY   = VGA_V_DISPLAY,
    parameter int   V_FRONT     = VGA_V_FRONT,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BACK      = VGA_V_BACK,
    parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
    input  logic                   clk25M,
    input  logic                   reset,
    output logic [COORD_W-1:0]     x,
    output logic [COORD_W-1:0]     y,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   video_on,
    output logic                   frame_tick,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Decode points as 10-bit unsigned constants so every compare is 10-bit
    localparam logic [COORD_W-1:0] H_VIS_END = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS_END = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_START  = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END    = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START  = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END    = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC);
    // Renderers update positions one line into vertical blanking
    localparam logic [COORD_W-1:0] TICK_Y    = COORD_W'(V_DISPLAY + 1);

    logic [COORD_W-1:0] h_q;
    logic [COORD_W-1:0] h_d;
    logic [COORD_W-1:0] v_q;
    logic [COORD_W-1:0] v_d;
    logic               h_wrap;
    // End of frame is decoded from next-state coordinates, so the v wrap is not consumed
    logic               v_wrap_unused;

    logic hsync_q;
    logic hsync_d;
    logic vsync_q;
    logic vsync_d;
    logic video_on_q;
    logic video_on_d;
    logic frame_tick_q;
    logic frame_tick_d;

    wrap_counter #(
        .W (COORD_W),
        .N (H_TOTAL)
    ) u_h_cnt (
        .clk25M  (clk25M),
        .reset   (reset),
        .en_i    (1'b1),
        .count_o (h_q),
        .next_o  (h_d),
        .wrap_o  (h_wrap)
    );

    wrap_counter #(
        .W (COORD_W),
        .N (V_TOTAL)
    ) u_v_cnt (
        .clk25M  (clk25M),
        .reset   (reset),
        .en_i    (h_wrap),
        .count_o (v_q),
        .next_o  (v_d),
        .wrap_o  (v_wrap_unused)
    );

    // Decode flags from the coordinates the counters are about to take
    always_comb begin
        hsync_d      = in_window(h_d, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d      = in_window(v_d, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        video_on_d   = (h_d < H_VIS_END) && (v_d < V_VIS_END);
        frame_tick_d = (h_d == '0) && (v_d == TICK_Y);
    end

    // Flag registers; reset drops any sync pulse in progress at once
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            hsync_q      <= ~SYNC_ACTIVE;
            vsync_q      <= ~SYNC_ACTIVE;
            video_on_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            video_on_q   <= video_on_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign x          = h_q;
    assign y          = v_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = video_on_q;
    assign frame_tick = frame_tick_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_d;

    // Count completed frames, stepping the cycle after frame_tick; wraps naturally
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_tick_q) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    // Frame counter register
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_count = frame_cnt_q;
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a full-size instance for line/reset timing and a
// shrunken instance (inverted sync polarity) for whole-frame behaviour.
// Expected outputs come from a time-based raster model.
module tb_vga_sync;

    // Full 640x480 timing
    localparam int F_HD = 640, F_HF = 16, F_HS = 96, F_HB = 48;
    localparam int F_VD = 480, F_VF = 10, F_VS = 2,  F_VB = 33;
    localparam int F_HT = 800;

    // Shrunken timing so several frames fit in a short run
    localparam int S_HD = 20, S_HF = 3, S_HS = 5, S_HB = 4;
    localparam int S_VD = 10, S_VF = 2, S_VS = 3, S_VB = 2;
    localparam int S_HT = 32, S_VT = 17;
    localparam int S_FRAME = S_HT * S_VT;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       ft;
    } exp_t;

    logic        clk25M = 1'b0;
    logic        reset  = 1'b1;

    logic [9:0]  f_x, f_y, s_x, s_y;
    logic        f_hs, f_vs, f_von, f_ft;
    logic        s_hs, s_vs, s_von, s_ft;
    logic [15:0] f_fc, s_fc;

    int     n_chk  = 0;
    int     n_fail = 0;
    longint t      = 0;   // clock edges since reset release

    always #20 clk25M = ~clk25M;

    vga_sync dut_full (
        .clk25M      (clk25M),
        .reset       (reset),
        .x           (f_x),
        .y           (f_y),
        .hsync       (f_hs),
        .vsync       (f_vs),
        .video_on    (f_von),
        .frame_tick  (f_ft),
        .frame_count (f_fc)
    );

    vga_sync #(
        .H_DISPLAY   (S_HD), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_DISPLAY   (S_VD), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
        .SYNC_ACTIVE (1'b1)
    ) dut_small (
        .clk25M      (clk25M),
        .reset       (reset),
        .x           (s_x),
        .y           (s_y),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .video_on    (s_von),
        .frame_tick  (s_ft),
        .frame_count (s_fc)
    );

    // Raster position is simply elapsed edges modulo the frame length
    function automatic exp_t model(input longint tt, input int hd, input int hf, input int hsw,
                                   input int hb, input int vd, input int vf, input int vsw,
                                   input int vb, input logic sa);
        int     ht, vt, px, py;
        longint pos;
        exp_t   e;
        ht    = hd + hf + hsw + hb;
        vt    = vd + vf + vsw + vb;
        pos   = tt % longint'(ht * vt);
        px    = int'(pos % longint'(ht));
        py    = int'(pos / longint'(ht));
        e.x   = 10'(px);
        e.y   = 10'(py);
        e.hs  = (px >= hd + hf && px < hd + hf + hsw) ? sa : ~sa;
        e.vs  = (py >= vd + vf && py < vd + vf + vsw) ? sa : ~sa;
        e.von = (tt > 0) && (px < hd) && (py < vd);
        e.ft  = (tt > 0) && (px == 0) && (py == vd + 1);
        return e;
    endfunction

    function automatic exp_t exp_full(input longint tt);
        return model(tt, F_HD, F_HF, F_HS, F_HB, F_VD, F_VF, F_VS, F_VB, 1'b0);
    endfunction

    function automatic exp_t exp_small(input longint tt);
        return model(tt, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB, 1'b1);
    endfunction

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk25M);
        #1;
        if (!reset) t++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        t     = 0;
        repeat (5) tick();
        n_chk++; if (f_x !== 10'd0)   begin n_fail++; $display("FAIL reset_x: got %0d want 0", f_x); end
        n_chk++; if (f_y !== 10'd0)   begin n_fail++; $display("FAIL reset_y: got %0d want 0", f_y); end
        n_chk++; if (f_hs !== 1'b1)   begin n_fail++; $display("FAIL reset_hsync: got %b want 1", f_hs); end
        n_chk++; if (f_vs !== 1'b1)   begin n_fail++; $display("FAIL reset_vsync: got %b want 1", f_vs); end
        n_chk++; if (f_von !== 1'b0)  begin n_fail++; $display("FAIL reset_video_on: got %b want 0", f_von); end
        n_chk++; if (f_ft !== 1'b0)   begin n_fail++; $display("FAIL reset_frame_tick: got %b want 0", f_ft); end
        n_chk++; if (f_fc !== 16'h0)  begin n_fail++; $display("FAIL reset_frame_count: got %h want 0", f_fc); end
        n_chk++; if ({s_x, s_y, s_hs, s_vs, s_von, s_ft} !== 24'h0)
            begin n_fail++; $display("FAIL reset_small: got %h want 000000", {s_x, s_y, s_hs, s_vs, s_von, s_ft}); end
        @(negedge clk25M);
        reset = 1'b0;
        tick();
        n_chk++; if (f_x !== 10'd1)   begin n_fail++; $display("FAIL first_edge_x: got %0d want 1", f_x); end
        n_chk++; if (f_y !== 10'd0)   begin n_fail++; $display("FAIL first_edge_y: got %0d want 0", f_y); end
        n_chk++; if (f_von !== 1'b1)  begin n_fail++; $display("FAIL first_edge_video_on: got %b want 1", f_von); end
    endtask

    task automatic test_line_timing();
        exp_t       e;
        int         hs_low = 0, lo_x = -1, hi_x = -1;
        logic [9:0] px, py;
        for (int i = 0; i < 2 * F_HT + 5; i++) begin
            px = f_x;
            py = f_y;
            tick();
            e = exp_full(t);
            n_chk++;
            if ({f_x, f_y, f_hs, f_vs, f_von, f_ft} !== e) begin
                n_fail++;
                $display("FAIL line_cycle t=%0d: got %h want %h", t, {f_x, f_y, f_hs, f_vs, f_von, f_ft}, e);
            end
            if (f_y == 10'd0 && f_hs == 1'b0) begin
                hs_low++;
                if (lo_x < 0) lo_x = int'(f_x);
                hi_x = int'(f_x);
            end
            if (e.x == 10'd0 && e.y == 10'd1) begin
                n_chk++;
                if (px !== 10'd799 || py !== 10'd0 || f_x !== 10'd0 || f_y !== 10'd1) begin
                    n_fail++;
                    $display("FAIL line_wrap: got (%0d,%0d)->(%0d,%0d) want (799,0)->(0,1)", px, py, f_x, f_y);
                end
            end
            if (e.x == 10'd639 && e.y == 10'd0) begin
                n_chk++; if (f_von !== 1'b1) begin n_fail++; $display("FAIL active_639_0: got %b want 1", f_von); end
            end
            if (e.x == 10'd640 && e.y == 10'd0) begin
                n_chk++; if (f_von !== 1'b0) begin n_fail++; $display("FAIL active_640_0: got %b want 0", f_von); end
            end
        end
        n_chk++; if (hs_low != 96)  begin n_fail++; $display("FAIL hsync_width: got %0d want 96", hs_low); end
        n_chk++; if (lo_x != 656)   begin n_fail++; $display("FAIL hsync_first_x: got %0d want 656", lo_x); end
        n_chk++; if (hi_x != 751)   begin n_fail++; $display("FAIL hsync_last_x: got %0d want 751", hi_x); end
    endtask

    task automatic test_frame_timing();
        exp_t       e;
        longint     last_tick = -1;
        int         vs_cnt = 0, n_ticks = 0;
        logic [9:0] px, py;
        for (int i = 0; i < 3 * S_FRAME + 20; i++) begin
            px = s_x;
            py = s_y;
            tick();
            e = exp_small(t);
            n_chk++;
            if ({s_x, s_y, s_hs, s_vs, s_von, s_ft} !== e) begin
                n_fail++;
                $display("FAIL frame_cycle t=%0d: got %h want %h", t, {s_x, s_y, s_hs, s_vs, s_von, s_ft}, e);
            end
            if (s_vs == 1'b1) vs_cnt++;
            if (s_ft == 1'b1) begin
                n_chk++;
                if (s_x !== 10'd0 || s_y !== 10'(S_VD + 1)) begin
                    n_fail++; $display("FAIL tick_position: got (%0d,%0d) want (0,%0d)", s_x, s_y, S_VD + 1);
                end
                if (last_tick >= 0) begin
                    n_chk++;
                    if (t - last_tick != longint'(S_FRAME)) begin
                        n_fail++; $display("FAIL tick_period: got %0d want %0d", t - last_tick, S_FRAME);
                    end
                    n_chk++;
                    if (vs_cnt != S_VS * S_HT) begin
                        n_fail++; $display("FAIL vsync_width: got %0d want %0d", vs_cnt, S_VS * S_HT);
                    end
                end
                last_tick = t;
                vs_cnt    = 0;
                n_ticks++;
            end
            if (e.x == 10'd0 && e.y == 10'd0) begin
                n_chk++;
                if (px !== 10'(S_HT - 1) || py !== 10'(S_VT - 1)) begin
                    n_fail++; $display("FAIL frame_wrap: got prev (%0d,%0d) want (%0d,%0d)", px, py, S_HT - 1, S_VT - 1);
                end
            end
            if (e.x == 10'(S_HD - 1) && e.y == 10'd0) begin
                n_chk++; if (s_von !== 1'b1) begin n_fail++; $display("FAIL active_right_in: got %b want 1", s_von); end
            end
            if (e.x == 10'(S_HD) && e.y == 10'd0) begin
                n_chk++; if (s_von !== 1'b0) begin n_fail++; $display("FAIL active_right_out: got %b want 0", s_von); end
            end
            if (e.x == 10'd0 && e.y == 10'(S_VD - 1)) begin
                n_chk++; if (s_von !== 1'b1) begin n_fail++; $display("FAIL active_bottom_in: got %b want 1", s_von); end
            end
            if (e.x == 10'd0 && e.y == 10'(S_VD)) begin
                n_chk++; if (s_von !== 1'b0) begin n_fail++; $display("FAIL active_bottom_out: got %b want 0", s_von); end
            end
        end
        n_chk++; if (n_ticks != 3) begin n_fail++; $display("FAIL tick_count: got %0d want 3", n_ticks); end
    endtask

    task automatic test_mid_reset();
        exp_t ef, es;
        bit   found;
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(20, 1200)) tick();
            #4 reset = 1'b1;
            #1;
            ef = exp_full(0);
            es = exp_small(0);
            n_chk++;
            if ({f_x, f_y, f_hs, f_vs, f_von, f_ft} !== ef || f_fc !== 16'h0) begin
                n_fail++; $display("FAIL async_reset_full: got %h/%h want %h/0", {f_x, f_y, f_hs, f_vs, f_von, f_ft}, f_fc, ef);
            end
            n_chk++;
            if ({s_x, s_y, s_hs, s_vs, s_von, s_ft} !== es || s_fc !== 16'h0) begin
                n_fail++; $display("FAIL async_reset_small: got %h/%h want %h/0", {s_x, s_y, s_hs, s_vs, s_von, s_ft}, s_fc, es);
            end
            t = 0;
            repeat ($urandom_range(1, 4)) tick();
            @(negedge clk25M);
            reset = 1'b0;
            found = 1'b0;
            for (int i = 0; i < 2 * S_FRAME && !found; i++) begin
                tick();
                if (s_ft == 1'b1) found = 1'b1;
            end
            n_chk++;
            if (!found || t != longint'((S_VD + 1) * S_HT)) begin
                n_fail++; $display("FAIL restart_tick: got found=%0d t=%0d want t=%0d", found, t, (S_VD + 1) * S_HT);
            end
        end
    endtask

    task automatic test_frame_count();
        int ticks = 0;
        @(negedge clk25M);
        reset = 1'b1;
        t     = 0;
        repeat (2) tick();
        @(negedge clk25M);
        reset = 1'b0;
`ifdef VGA_SYNC_FRAME_CNT_EN
        for (int i = 0; i < 3 * S_FRAME + S_HT; i++) begin
            tick();
            n_chk++;
            if (s_fc !== 16'(ticks)) begin
                n_fail++; $display("FAIL frame_count t=%0d: got %0d want %0d", t, s_fc, ticks);
            end
            if (s_ft == 1'b1) ticks++;
        end
        n_chk++; if (s_fc !== 16'd3) begin n_fail++; $display("FAIL frame_count_final: got %0d want 3", s_fc); end
`else
        for (int i = 0; i < S_FRAME + S_HT; i++) begin
            tick();
            if (s_ft == 1'b1) ticks++;
            n_chk++;
            if (s_fc !== 16'h0 || f_fc !== 16'h0) begin
                n_fail++; $display("FAIL frame_count_tied t=%0d: got %h/%h want 0/0", t, s_fc, f_fc);
            end
        end
        n_chk++; if (ticks != 1) begin n_fail++; $display("FAIL frame_count_run_ticks: got %0d want 1", ticks); end
`endif
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_mid_reset();
        test_frame_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
